maxpool_window_reader: RTL and testbench
========================================

MAXPOOL_WINDOW_READER -- requirements
Module: maxpool_window_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the bit width of one signed two's-complement pixel.
REQ-002 The block SHALL have parameter WIDTH_IMG, default 26, meaning input pixels per row (>=2).
REQ-003 The block SHALL have parameter HEIGHT_IMG, default 26, meaning input rows per frame (>=2).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 en  input  1  window/pixel valid strobe, one input pixel per cycle when high.
REQ-007 in0  input  DATA_WIDTH  window top-left (previous pixel, previous row).
REQ-008 in1  input  DATA_WIDTH  window top-right (current column, previous row).
REQ-009 in2  input  DATA_WIDTH  window bottom-left (previous pixel, current row).
REQ-010 in3  input  DATA_WIDTH  window bottom-right (current pixel, current row).
REQ-011 pool_out  output  DATA_WIDTH  pooled maximum of one 2x2 window.
REQ-012 pool_valid  output  1  one-cycle qualifier for pool_out.
REQ-013 done  output  1  one-cycle pulse after the last pooled output of a frame.
REQ-014 busy  output  1  high while a frame is in progress (state RUN).

Function
REQ-015 The block SHALL keep column counter col (0..WIDTH_IMG-1) and row counter row (0..HEIGHT_IMG-1), advancing col only on cycles with en=1; col wraps to 0 and row increments after WIDTH_IMG-1.
REQ-016 A window SHALL be accepted when en=1, col is odd and row is odd (0-based), i.e. stride-2, non-overlapping 2x2 pooling.
REQ-017 For an accepted window, pool_out SHALL equal the signed maximum of in0..in3, registered; pool_valid SHALL be high exactly one cycle later (latency 1).
REQ-018 Ties SHALL select the equal value (result value-identical; no index output).
REQ-019 If WIDTH_IMG or HEIGHT_IMG is odd, the last column/row SHALL be consumed but never produce output (floor pooling).
REQ-020 Outputs per frame SHALL be exactly floor(WIDTH_IMG/2)*floor(HEIGHT_IMG/2) (169 at defaults).
REQ-021 FSM states SHALL be IDLE, RUN, DONE: IDLE->RUN on first en=1 (that pixel counted as col 0,row 0); RUN->DONE on en=1 at row=HEIGHT_IMG-1,col=WIDTH_IMG-1; DONE->IDLE unconditionally next cycle.
REQ-022 done SHALL be high during the DONE state only, coinciding with pool_valid of the final window.
REQ-023 en=0 SHALL stall counters and FSM; pool_valid SHALL be 0 on any cycle not following an accepted window.
REQ-024 en=1 while in DONE SHALL be counted as col 0,row 0 of a new frame and the FSM SHALL go to RUN (back-to-back frames, no lost pixel).
REQ-025 pool_out SHALL hold its last value when pool_valid=0.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, col=0, row=0, pool_out=0, pool_valid=0, done=0, busy=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; no done pulse SHALL be emitted for it.
REQ-028 After rst_n rises, the next en=1 SHALL be treated as pixel (0,0).

Configuration
REQ-029 Macro MAXPOOL_RELU_EN: when defined, pool_out SHALL be max(0, max(in0..in3)) (negative results clamp to 0); when undefined, pool_out SHALL be the raw signed maximum; latency and counts unchanged either way.

Verification
REQ-030 Reset: hold rst_n=0 with en toggling -> all outputs 0, busy=0.
REQ-031 4x4 frame (params 4,4), in3 ramp 1..16 with matching window taps -> exactly 4 pool_valid pulses, values 6,8,14,16, done with the 4th.
REQ-032 Window in0..in3 = -5,-2,-9,-7 -> pool_out = -2 without MAXPOOL_RELU_EN, 0 with it.
REQ-033 Default 26x26 frame with en de-asserted every third cycle -> 169 pool_valid pulses, one done, busy low afterwards.
REQ-034 Two back-to-back frames with en continuously 1 -> 338 pulses, two done pulses, no gap in counting.
REQ-035 Assert rst_n=0 at row 10 col 7 then replay full frame -> no done for the aborted frame, 169 correct outputs for the replay.

Source files
------------

// File: rtl/maxpool_window_reader.sv
// Purpose : stride-2, non-overlapping 2x2 max pooling over a raster-scanned frame,
//           with an IDLE/RUN/DONE frame sequencer and an end-of-frame done pulse.
// Latency : 1 cycle from an accepted window (en=1, odd col, odd row) to pool_valid.
// Backpressure: none; en=0 stalls the counters and the FSM, and pool_out holds.
//
// Ports:
//   clk, rst_n         single clock, asynchronous active-low reset
//   en                 one input pixel (and its 2x2 window taps) per cycle when high
//   in0..in3           window taps: TL, TR, BL, BR (BR is the current pixel)
//   pool_out           registered signed maximum of the last accepted window
//   pool_valid         one-cycle qualifier for pool_out
//   done               high in DONE only, together with the frame's final pool_valid
//   busy               high while in RUN
//
// Optional feature: define MAXPOOL_RELU_EN to clamp negative maxima to zero.
module maxpool_window_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH_IMG  = 26,
    parameter int HEIGHT_IMG = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    output logic [DATA_WIDTH-1:0] pool_out,
    output logic                  pool_valid,
    output logic                  done,
    output logic                  busy
);

    localparam int CW = (WIDTH_IMG  > 2) ? $clog2(WIDTH_IMG)  : 1;
    localparam int RW = (HEIGHT_IMG > 2) ? $clog2(HEIGHT_IMG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] pool_out_q, pool_out_d;
    logic                  pool_valid_q, pool_valid_d;

    logic                  last_col;
    logic                  last_pix;
    logic                  accept;

    logic signed [DATA_WIDTH-1:0] s0, s1, s2, s3;
    logic signed [DATA_WIDTH-1:0] m_top, m_bot, m_all;
    logic signed [DATA_WIDTH-1:0] m_res;

    // Signed comparison tree; on ties either operand is the same value.
    always_comb begin
        s0    = $signed(in0);
        s1    = $signed(in1);
        s2    = $signed(in2);
        s3    = $signed(in3);
        m_top = (s0 > s1) ? s0 : s1;
        m_bot = (s2 > s3) ? s2 : s3;
        m_all = (m_top > m_bot) ? m_top : m_bot;
`ifdef MAXPOOL_RELU_EN
        m_res = m_all[DATA_WIDTH-1] ? '0 : m_all;
`else
        m_res = m_all;
`endif
    end

    always_comb begin
        last_col     = (col_q == CW'(WIDTH_IMG - 1));
        last_pix     = last_col && (row_q == RW'(HEIGHT_IMG - 1));
        // Odd col and odd row mark the bottom-right pixel of a stride-2 window;
        // a trailing odd-sized column/row never reaches this and is dropped.
        accept       = en && col_q[0] && row_q[0];

        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        pool_valid_d = accept;
        pool_out_d   = accept ? DATA_WIDTH'(m_res) : pool_out_q;

        // Counters wrap to (0,0) on the last pixel, so the pixel that starts a
        // frame from IDLE or DONE is always counted as (0,0).
        if (en) begin
            if (last_col) begin
                col_d = '0;
                row_d = (row_q == RW'(HEIGHT_IMG - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (en && last_pix) state_d = DONE;
            DONE:    state_d = en ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            pool_out_q   <= '0;
            pool_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pool_out_q   <= pool_out_d;
            pool_valid_q <= pool_valid_d;
        end
    end

    assign pool_out   = pool_out_q;
    assign pool_valid = pool_valid_q;
    assign done       = (state_q == DONE);
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_maxpool_window_reader.sv
module tb_maxpool_window_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4x4 instance for the directed table
    logic               en4 = 1'b0;
    logic signed [31:0] a0 = 0, a1 = 0, a2 = 0, a3 = 0;
    logic [31:0]        out4;
    logic               vld4, done4, busy4;

    // default 26x26 instance for the full-frame sequences
    logic               en26 = 1'b0;
    logic signed [31:0] b0 = 0, b1 = 0, b2 = 0, b3 = 0;
    logic [31:0]        out26;
    logic               vld26, done26, busy26;

    maxpool_window_reader #(.DATA_WIDTH(32), .WIDTH_IMG(4), .HEIGHT_IMG(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4),
        .in0(a0), .in1(a1), .in2(a2), .in3(a3),
        .pool_out(out4), .pool_valid(vld4), .done(done4), .busy(busy4)
    );

    maxpool_window_reader dut26 (
        .clk(clk), .rst_n(rst_n), .en(en26),
        .in0(b0), .in1(b1), .in2(b2), .in3(b3),
        .pool_out(out26), .pool_valid(vld26), .done(done26), .busy(busy26)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [31:0] mx(input logic signed [31:0] a, input logic signed [31:0] b,
                                              input logic signed [31:0] c, input logic signed [31:0] d);
        logic signed [31:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    typedef struct {
        logic               en;
        logic signed [31:0] i0, i1, i2, i3;
        logic               vld;
        logic signed [31:0] out;
        logic               dn;
        logic               bsy;
    } vec_t;

    function automatic vec_t mk(input logic e, input int i0, input int i1, input int i2, input int i3,
                                input logic v, input int o, input logic d, input logic b);
        vec_t t;
        t.en = e; t.i0 = i0; t.i1 = i1; t.i2 = i2; t.i3 = i3;
        t.vld = v; t.out = o; t.dn = d; t.bsy = b;
        return t;
    endfunction

    vec_t tbl [19];

    // One 4x4 step: drive, clock, then compare the post-edge outputs.
    task automatic step4(input logic e, input int i0, input int i1, input int i2, input int i3);
        en4 = e; a0 = i0; a1 = i1; a2 = i2; a3 = i3;
        @(posedge clk); #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 19; i++) begin
            step4(tbl[i].en, tbl[i].i0, tbl[i].i1, tbl[i].i2, tbl[i].i3);
            chk($sformatf("%s[%0d].valid", tag, i), {31'd0, vld4},  {31'd0, tbl[i].vld});
            chk($sformatf("%s[%0d].out",   tag, i), out4,           tbl[i].out);
            chk($sformatf("%s[%0d].done",  tag, i), {31'd0, done4}, {31'd0, tbl[i].dn});
            chk($sformatf("%s[%0d].busy",  tag, i), {31'd0, busy4}, {31'd0, tbl[i].bsy});
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out4"},   out4,            0);
        chk({tag, ".vld4"},   {31'd0, vld4},   0);
        chk({tag, ".done4"},  {31'd0, done4},  0);
        chk({tag, ".busy4"},  {31'd0, busy4},  0);
        chk({tag, ".out26"},  out26,           0);
        chk({tag, ".vld26"},  {31'd0, vld26},  0);
        chk({tag, ".done26"}, {31'd0, done26}, 0);
        chk({tag, ".busy26"}, {31'd0, busy26}, 0);
    endtask

    // Bench-side model of the 26x26 scan position and held output.
    int                 r26 = 0, c26 = 0, cyc26 = 0;
    int                 nv26 = 0, nd26 = 0;
    logic signed [31:0] hold26 = 0;

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_all_zero({tag, ".async"});
        for (int k = 0; k < 4; k++) begin
            en4 = ~en4; en26 = ~en26;
            a3 = 32'(k + 7); b3 = 32'(k + 9);
            @(posedge clk); #1;
            chk_all_zero($sformatf("%s.hold%0d", tag, k));
        end
        en4 = 1'b0; en26 = 1'b0;
        rst_n = 1'b1;
        r26 = 0; c26 = 0; hold26 = 0;
    endtask

    task automatic drive26(input string tag, input int npix, input bit stall3);
        logic exp_v, exp_d;
        int p;
        p = 0;
        while (p < npix) begin
            b0 = $urandom; b1 = $urandom; b2 = $urandom; b3 = $urandom;
            if (stall3 && (cyc26 % 3 == 2)) begin
                en26 = 1'b0; exp_v = 1'b0; exp_d = 1'b0;
            end else begin
                en26  = 1'b1;
                exp_v = (r26 % 2 == 1) && (c26 % 2 == 1);
                exp_d = (r26 == 25) && (c26 == 25);
                if (exp_v) hold26 = mx(b0, b1, b2, b3);
                c26++;
                if (c26 == 26) begin c26 = 0; r26++; end
                if (r26 == 26) r26 = 0;
                p++;
            end
            cyc26++;
            @(posedge clk); #1;
            chk($sformatf("%s.valid@%0d", tag, p), {31'd0, vld26},  {31'd0, exp_v});
            chk($sformatf("%s.done@%0d",  tag, p), {31'd0, done26}, {31'd0, exp_d});
            chk($sformatf("%s.out@%0d",   tag, p), out26, hold26);
            if (vld26)  nv26++;
            if (done26) nd26++;
        end
        en26 = 1'b0;
    endtask

    initial begin
        // 4x4 ramp: pixel(r,c) = 4r+c+1; taps TL,TR,BL,BR, 0 outside the frame.
        tbl[0]  = mk(1,  0,  0,  0,  1, 0,  0, 0, 1);
        tbl[1]  = mk(1,  0,  0,  1,  2, 0,  0, 0, 1);
        tbl[2]  = mk(1,  0,  0,  2,  3, 0,  0, 0, 1);
        tbl[3]  = mk(1,  0,  0,  3,  4, 0,  0, 0, 1);
        tbl[4]  = mk(1,  0,  1,  0,  5, 0,  0, 0, 1);
        tbl[5]  = mk(1,  1,  2,  5,  6, 1,  6, 0, 1);
        tbl[6]  = mk(0, 99, 99, 99, 99, 0,  6, 0, 1);
        tbl[7]  = mk(1,  2,  3,  6,  7, 0,  6, 0, 1);
        tbl[8]  = mk(1,  3,  4,  7,  8, 1,  8, 0, 1);
        tbl[9]  = mk(1,  0,  5,  0,  9, 0,  8, 0, 1);
        tbl[10] = mk(1,  5,  6,  9, 10, 0,  8, 0, 1);
        tbl[11] = mk(1,  6,  7, 10, 11, 0,  8, 0, 1);
        tbl[12] = mk(1,  7,  8, 11, 12, 0,  8, 0, 1);
        tbl[13] = mk(1,  0,  9,  0, 13, 0,  8, 0, 1);
        tbl[14] = mk(1,  9, 10, 13, 14, 1, 14, 0, 1);
        tbl[15] = mk(1, 10, 11, 14, 15, 0, 14, 0, 1);
        tbl[16] = mk(1, 11, 12, 15, 16, 1, 16, 1, 0);
        tbl[17] = mk(0, 50, 50, 50, 50, 0, 16, 0, 0);
        tbl[18] = mk(0, 50, 50, 50, 50, 0, 16, 0, 0);

        do_reset("rst0");
        run_table("ramp");

        // Negative window and tie window inside a new 4x4 frame.
        for (int k = 0; k < 5; k++) step4(1, 0, 0, 0, 0);
        step4(1, -5, -2, -9, -7);
        chk("neg.valid", {31'd0, vld4}, 1);
`ifdef MAXPOOL_RELU_EN
        chk("neg.out", out4, 0);
`else
        chk("neg.out", out4, -2);
`endif
        step4(1, 0, 0, 0, 0);
        step4(1, 7, 3, 7, 7);
        chk("tie.valid", {31'd0, vld4}, 1);
        chk("tie.out", out4, 7);
        // Abort this 4x4 frame mid-way; the table must replay from (0,0).
        step4(1, 0, 0, 0, 0);
        do_reset("rst1");
        run_table("replay4");

        // 26x26 with every third cycle stalled.
        nv26 = 0; nd26 = 0; cyc26 = 0;
        drive26("stall", 676, 1'b1);
        @(posedge clk); #1;
        chk("stall.pulses", nv26, 169);
        chk("stall.dones", nd26, 1);
        chk("stall.busy_after", {31'd0, busy26}, 0);

        // Two back-to-back frames, en held high throughout.
        nv26 = 0; nd26 = 0;
        drive26("b2b", 1352, 1'b0);
        @(posedge clk); #1;
        chk("b2b.pulses", nv26, 338);
        chk("b2b.dones", nd26, 2);
        chk("b2b.busy_after", {31'd0, busy26}, 0);

        // Abort at row 10 col 7, then replay a full frame.
        nv26 = 0; nd26 = 0;
        drive26("abort", 10 * 26 + 7, 1'b0);
        chk("abort.busy", {31'd0, busy26}, 1);
        do_reset("rst2");
        chk("abort.dones", nd26, 0);
        nv26 = 0;
        drive26("replay26", 676, 1'b0);
        @(posedge clk); #1;
        chk("replay26.pulses", nv26, 169);
        chk("replay26.dones", nd26, 1);
        chk("replay26.busy_after", {31'd0, busy26}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
